// File: rtl/mux_x_adc_interleave.sv
// N-channel interleaved-ADC sample selector: manual or round-robin channel choice, registered output with valid/ready.
// Optional per-channel signed offset subtraction with saturation when X_ADC_OFFSET_EN is defined.
module mux_x_adc_interleave #(
   parameter int DATA_W = 32,
   parameter int NCH    = 8,
   parameter int SEL_W  = $clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  GlobalReset,
   input  logic [NCH*DATA_W-1:0] x_adc_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode_auto,
   input  logic [SEL_W-1:0]      x_adc_select,
   input  logic [NCH-1:0]        ch_en,
   input  logic                  sync_clr,
   output logic [DATA_W-1:0]     x_adc,
   output logic [SEL_W-1:0]      x_adc_ch,
   output logic                  x_adc_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sel_err
`ifdef X_ADC_OFFSET_EN
   ,
   input  logic                      ofs_wr,
   input  logic [SEL_W-1:0]          ofs_addr,
   input  logic signed [DATA_W-1:0]  ofs_data
`endif
);

   function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] m);
      logic [SEL_W-1:0] r;
      r = '0;
      for (int k = NCH-1; k >= 0; k--) begin
         if (m[k]) r = SEL_W'(k);
      end
      return r;
   endfunction

`ifdef X_ADC_OFFSET_EN
   function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
      logic signed [DATA_W:0] d;
      d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
      if (d[DATA_W] != d[DATA_W-1])
         return d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      return d[DATA_W-1:0];
   endfunction
`endif

   logic [DATA_W-1:0] samples [NCH];
   logic [NCH-1:0]    above_p0;
   logic [SEL_W-1:0]  wrap_p0;
   logic [SEL_W-1:0]  next_ptr_p0;
   logic [SEL_W-1:0]  chan_p0;
   logic [DATA_W-1:0] sample_p0;
   logic              sel_oob_p0;
   logic              last_auto_p0;
   logic              xfer_p0;

   logic [SEL_W-1:0]  ptr;
   logic [DATA_W-1:0] data_p1;
   logic [SEL_W-1:0]  ch_p1;
   logic              last_p1;
   logic              vld_p1;
   logic              err_p1;

   // stage p0: channel choice, next-pointer search and handshake
   always_comb begin
      for (int k = 0; k < NCH; k++) samples[k] = x_adc_in[k*DATA_W +: DATA_W];
   end

   always_comb begin
      above_p0 = '0;
      for (int k = 0; k < NCH; k++) above_p0[k] = ch_en[k] && (k > int'(ptr));
   end

   assign wrap_p0      = lowest_set(ch_en);
   assign last_auto_p0 = ~|above_p0;
   assign next_ptr_p0  = last_auto_p0 ? wrap_p0 : lowest_set(above_p0);
   assign sel_oob_p0   = {1'b0, x_adc_select} >= (SEL_W+1)'(NCH);
   assign chan_p0      = mode_auto ? ptr : (sel_oob_p0 ? '0 : x_adc_select);

   assign in_ready = (!vld_p1 || out_ready) && !sync_clr && (mode_auto ? |ch_en : 1'b1);
   assign xfer_p0  = in_valid && in_ready;

`ifdef X_ADC_OFFSET_EN
   logic signed [DATA_W-1:0] ofs_p1 [NCH];

   // Written offsets take effect on the following transfer.
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         for (int k = 0; k < NCH; k++) ofs_p1[k] <= '0;
      end else if (ofs_wr && ({1'b0, ofs_addr} < (SEL_W+1)'(NCH))) begin
         ofs_p1[ofs_addr] <= ofs_data;
      end
   end

   assign sample_p0 = sat_sub(samples[chan_p0], ofs_p1[chan_p0]);
`else
   assign sample_p0 = samples[chan_p0];
`endif

   // stage p1: registered output sample and sequencer state
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         data_p1 <= '0;
         ch_p1   <= '0;
         last_p1 <= 1'b0;
         vld_p1  <= 1'b0;
         err_p1  <= 1'b0;
         ptr     <= '0;
      end else if (sync_clr) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         err_p1  <= 1'b0;
         ptr     <= wrap_p0;
      end else if (xfer_p0) begin
         data_p1 <= sample_p0;
         ch_p1   <= chan_p0;
         last_p1 <= mode_auto && last_auto_p0;
         vld_p1  <= 1'b1;
         if (!mode_auto && sel_oob_p0) err_p1 <= 1'b1;
         if (mode_auto) ptr <= next_ptr_p0;
      end else if (vld_p1 && out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign x_adc      = data_p1;
   assign x_adc_ch   = ch_p1;
   assign x_adc_last = last_p1;
   assign out_valid  = vld_p1;
   assign sel_err    = err_p1;

endmodule

// File: doc/mux_x_adc_interleave.md
Name: mux_x_adc_interleave

Overview:
Parametrised N-channel interleaved-ADC sample selector for the x_adc datapath. It supports manual select, or an automatic round-robin sequencer over a channel-enable mask. It has a registered output with valid/ready backpressure and a channel tag. It sits between the ADC channel registers and the downstream x_adc consumer, and generalises the fixed 8x32 one-cycle mux to any width or channel count with flow control and frame marking.

Parameters:
DATA_W, 32, sample width in bits
NCH, 8, number of ADC channels (2..64)
SEL_W, $clog2(NCH), channel index width (derived; do not override)

Ports:
clk  in  1  clock, all logic on posedge
GlobalReset  in  1  asynchronous, active-low reset (0 = reset asserted)
x_adc_in  in  NCH*DATA_W  packed channel samples, channel k at bits [k*DATA_W +: DATA_W]
in_valid  in  1  x_adc_in bus valid this cycle
in_ready  out  1  block accepts this cycle
mode_auto  in  1  0 = manual (x_adc_select), 1 = round-robin over ch_en
x_adc_select  in  SEL_W  manual channel index
ch_en  in  NCH  channel enable mask for auto mode
sync_clr  in  1  synchronous restart: flush output, reload sequencer, clear sel_err
x_adc  out  DATA_W  selected sample (registered)
x_adc_ch  out  SEL_W  channel index of x_adc
x_adc_last  out  1  x_adc is the last enabled channel of an auto frame
out_valid  out  1  x_adc valid
out_ready  in  1  downstream accepts
sel_err  out  1  sticky: manual x_adc_select >= NCH seen on an accepted transfer

Behaviour:
- Reset (GlobalReset=0, async): x_adc=0, x_adc_ch=0, x_adc_last=0, out_valid=0, sel_err=0, ptr=0.
- in_ready = (!out_valid | out_ready) & !sync_clr & (mode_auto ? |ch_en : 1). The term is combinational, with no in_valid->in_ready path.
- Transfer (xfer) = in_valid & in_ready. Latency is 1 cycle: on xfer, x_adc, x_adc_ch and x_adc_last load and out_valid<=1.
- If out_valid & out_ready & !xfer, then out_valid<=0 and the data holds its last value.
- If out_valid & !out_ready, all outputs hold.
- Manual channel: chan = x_adc_select. If x_adc_select >= NCH, chan=0 and sel_err<=1 on xfer. x_adc_last=0 in manual mode.
- Auto channel: chan = ptr.
  - On xfer, ptr <= next enabled index above ptr, wrapping to the lowest enabled index.
  - x_adc_last=1 when no enabled index above ptr exists.
  - If ptr is the only enabled channel, ptr holds and every sample has last=1.
  - If ch_en changes and ptr points to a disabled channel, the transfer still uses ptr (ch_en is sampled for next-pointer only).
  - ch_en=0 -> in_ready=0 and ptr holds.
- sync_clr (priority over everything except reset): out_valid<=0, x_adc_last<=0, sel_err<=0, ptr<=lowest enabled index (0 if ch_en=0). No transfer occurs that cycle.
- Mode switch has no implicit restart; software issues sync_clr.
- Reset mid-transfer discards the pending output sample.
- Next-pointer logic is a priority search over rotated ch_en, with one cycle maximum combinational depth. No multicycle paths.

Optional Feature:
X_ADC_OFFSET_EN:
- Defined: adds ports ofs_wr (in, 1), ofs_addr (in, SEL_W) and ofs_data (in, DATA_W, signed), plus NCH offset registers reset to 0. On ofs_wr, offset[ofs_addr] <= ofs_data; ofs_addr >= NCH is ignored. The output becomes x_adc = sat(sample - offset[chan]) in signed DATA_W arithmetic, saturating to the max/min signed value. Latency stays 1 cycle. A write to the offset of the channel being transferred in the same cycle uses the old offset.
- Undefined: no ports or registers are added, and x_adc = raw sample.

Test Plan:
- Reset, manual, backpressure: NCH=8, DATA_W=32, channel k = 32'h1000_0000+k, GlobalReset 0->1, mode_auto=0, select=5, in_valid=1, out_ready=1 -> next cycle x_adc=32'h1000_0005, x_adc_ch=5, out_valid=1. Then out_ready=0 for 3 cycles -> outputs hold, in_ready=0.
- Auto frame marking: ch_en=8'b1010_0110, sync_clr pulse, continuous transfers -> x_adc_ch sequence 1,2,5,7,1,2; x_adc_last=1 only on channel 7.
- Empty and single-channel masks: ch_en=0 with in_valid=1 -> in_ready=0, out_valid stays 0. ch_en=8'b0000_1000 -> every output has ch=3, last=1.
- sync_clr collision and mid-operation reset: sync_clr asserted with in_valid=1, out_valid=1, out_ready=0 -> next cycle out_valid=0, ptr=lowest enabled. GlobalReset=0 mid-stream -> outputs 0 immediately, without waiting for a clock.
- Select error (NCH=6 build): select=7 manual -> x_adc = channel 0 sample, sel_err=1 and stays set until sync_clr.
- Offset correction (X_ADC_OFFSET_EN): offset[2] = 32'sd100, sample = 32'h8000_0010 -> x_adc = 32'h8000_0000 (saturated). offset[2] = -5, sample = 7 -> x_adc = 12.
